// File: rtl/gat_bram_lane_adapter.sv
// Host-to-BRAM lane adapter: assembles 32-bit host lanes into one wide memory word on write,
// and returns one lane of a wide word on read after a fixed latency.
module gat_bram_lane_adapter #(
  parameter int unsigned TOP_WIDTH      = 32,
  parameter int unsigned MEM_WIDTH      = 103,
  parameter int unsigned MEM_DEPTH      = 2708,
  parameter int unsigned MEM_RD_LATENCY = 2,
  parameter int unsigned EXPECTED_WORDS = MEM_DEPTH,
  localparam int unsigned LANES      = (MEM_WIDTH + TOP_WIDTH - 1) / TOP_WIDTH,
  localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned MEM_ADDR_W = $clog2(MEM_DEPTH),
  localparam int unsigned STRB_W     = TOP_WIDTH / 8,
  localparam int unsigned ADDR_W     = MEM_ADDR_W + LANE_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_clear,
  input  logic                    bram_ena,
  input  logic [STRB_W-1:0]       bram_wea,
  input  logic [ADDR_W-1:0]       bram_addra,
  input  logic [TOP_WIDTH-1:0]    bram_din,
  output logic [TOP_WIDTH-1:0]    bram_dout,
  output logic                    mem_we,
  output logic [MEM_ADDR_W-1:0]   mem_waddr,
  output logic [MEM_WIDTH-1:0]    mem_wdata,
  output logic                    mem_re,
  output logic [MEM_ADDR_W-1:0]   mem_raddr,
  input  logic [MEM_WIDTH-1:0]    mem_rdata,
  output logic                    load_done,
  output logic [MEM_ADDR_W:0]     words_written,
  output logic                    seq_err
);

  localparam int unsigned SHADOW_W = LANES * TOP_WIDTH;
  localparam int unsigned CNT_W    = MEM_ADDR_W + 1;
  localparam logic [LANE_W:0]   LANES_L   = (LANE_W + 1)'(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  EXP_CNT   = CNT_W'(EXPECTED_WORDS);

  logic [LANE_W-1:0]     lane_c;
  logic [MEM_ADDR_W-1:0] word_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  lane_ok_c;
  logic                  unused_addr_c;

  logic [LANE_W-1:0]     exp_lane_q, exp_lane_d;
  logic [MEM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [SHADOW_W-1:0]   merged_c;
  logic                  seq_err_d;
  logic                  commit_c;

  logic [MEM_RD_LATENCY-1:0] rd_vld_q;
  logic [LANE_W-1:0]         rd_lane_q [MEM_RD_LATENCY];
  logic [SHADOW_W-1:0]       rdata_ext_c;
  logic [TOP_WIDTH-1:0]      rd_sel_c;

  // Address decode: {word, lane, byte offset}; the byte offset is ignored.
  assign lane_c        = bram_addra[LANE_W+1:2];
  assign word_c        = bram_addra[ADDR_W-1:LANE_W+2];
  assign unused_addr_c = ^bram_addra[1:0];
  assign wr_c          = bram_ena && (bram_wea != '0);
  assign rd_c          = bram_ena && (bram_wea == '0);
  assign lane_ok_c     = ({1'b0, lane_c} < LANES_L);

  assign mem_re    = rst_n && rd_c;
  assign mem_raddr = word_c;

  // Byte-wise merge of the incoming lane into the shadow word.
  always_comb begin
    merged_c = shadow_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if ((lane_c == LANE_W'(l)) && bram_wea[b]) begin
          merged_c[l*TOP_WIDTH + b*8 +: 8] = bram_din[b*8 +: 8];
        end
      end
    end
  end

  // Lane-order tracking; lane 0 always restarts assembly.
  always_comb begin
    exp_lane_d = exp_lane_q;
    wr_addr_d  = wr_addr_q;
    shadow_d   = shadow_q;
    seq_err_d  = seq_err;
    commit_c   = 1'b0;
    if (load_clear) begin
      exp_lane_d = '0;
      seq_err_d  = 1'b0;
    end else if (wr_c && lane_ok_c) begin
      if ((lane_c == '0) || ((lane_c == exp_lane_q) && (word_c == wr_addr_q))) begin
        shadow_d  = merged_c;
        wr_addr_d = word_c;
        if (lane_c == LAST_LANE) begin
          commit_c   = 1'b1;
          exp_lane_d = '0;
        end else begin
          exp_lane_d = lane_c + 1'b1;
        end
      end else begin
        seq_err_d  = 1'b1;
        exp_lane_d = '0;
      end
    end
  end

  // Write-side state, commit outputs, counter and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_lane_q    <= '0;
      wr_addr_q     <= '0;
      shadow_q      <= '0;
      seq_err       <= 1'b0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
      load_done     <= 1'b0;
    end else begin
      exp_lane_q <= exp_lane_d;
      wr_addr_q  <= wr_addr_d;
      shadow_q   <= shadow_d;
      seq_err    <= seq_err_d;
      mem_we     <= commit_c;
      if (commit_c) begin
        mem_waddr <= wr_addr_d;
        mem_wdata <= merged_c[MEM_WIDTH-1:0];
      end
      if (load_clear) begin
        words_written <= '0;
      end else if (commit_c && (words_written < EXP_CNT)) begin
        words_written <= words_written + 1'b1;
      end
      load_done <= !load_clear && (words_written == EXP_CNT);
    end
  end

  // Lane select on the returning wide word; padding lanes read as zero.
  assign rdata_ext_c = SHADOW_W'(mem_rdata);

  always_comb begin
    rd_sel_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (rd_lane_q[MEM_RD_LATENCY-1] == LANE_W'(l)) begin
        rd_sel_c = rdata_ext_c[l*TOP_WIDTH +: TOP_WIDTH];
      end
    end
  end

  // Read delay line matching the memory latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q  <= '0;
      bram_dout <= '0;
      for (int unsigned i = 0; i < MEM_RD_LATENCY; i++) begin
        rd_lane_q[i] <= '0;
      end
    end else begin
      rd_vld_q[0]  <= rd_c;
      rd_lane_q[0] <= lane_c;
      for (int unsigned i = 1; i < MEM_RD_LATENCY; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_lane_q[i] <= rd_lane_q[i-1];
      end
      if (rd_vld_q[MEM_RD_LATENCY-1]) begin
        bram_dout <= rd_sel_c;
      end
    end
  end

endmodule

// File: tb/tb_gat_bram_lane_adapter.sv
// Self-checking bench for gat_bram_lane_adapter: directed scenarios plus a randomized phase,
// checked against a lane/byte-level reference model and a 2-cycle-latency memory model.
module tb_gat_bram_lane_adapter;

  localparam int EXPW  = 3;
  localparam int LANES = 4;
  localparam logic [102:0] PRE7 = 103'h12_3456789A_DEADBEEF_CAFEF00D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_clear;
  logic         bram_ena;
  logic [3:0]   bram_wea;
  logic [15:0]  bram_addra;
  logic [31:0]  bram_din;
  logic [31:0]  bram_dout;
  logic         mem_we;
  logic [11:0]  mem_waddr;
  logic [102:0] mem_wdata;
  logic         mem_re;
  logic [11:0]  mem_raddr;
  logic [102:0] mem_rdata;
  logic         load_done;
  logic [12:0]  words_written;
  logic         seq_err;

  gat_bram_lane_adapter #(.EXPECTED_WORDS(EXPW)) dut (
    .clk(clk), .rst_n(rst_n), .load_clear(load_clear),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_din(bram_din),
    .bram_dout(bram_dout), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .load_done(load_done), .words_written(words_written), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Wide memory with 2-cycle read latency (16 words are enough for this bench).
  logic         preload = 1'b1;
  logic [102:0] tmem [16];
  logic [102:0] rd_stage;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) tmem[i] <= (i == 7) ? PRE7 : 103'd0;
    end else begin
      if (mem_we) tmem[mem_waddr[3:0]] <= mem_wdata;
      if (mem_re) rd_stage <= tmem[mem_raddr[3:0]];
      mem_rdata <= rd_stage;
    end
  end

  // Reference model state.
  int           vectors = 0;
  int           errors  = 0;
  int           cyc     = 0;
  logic [7:0]   sh [4][4];
  logic [102:0] ref_mem [16];
  int           m_exp   = 0;
  int           m_count = 0;
  int           m_addr  = 0;
  bit           m_seq   = 1'b0;
  logic [31:0]  dout_exp = 32'd0;
  int           rd_due[$];
  logic [31:0]  rd_val[$];
  bit           last_commit;
  logic [11:0]  c_addr;
  logic [102:0] c_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [102:0] shadow_word();
    logic [127:0] full;
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 4; b++) full[l*32 + b*8 +: 8] = sh[l][b];
    return full[102:0];
  endfunction

  // One host cycle: drive, predict, check combinational read port, clock, check registered outputs.
  task automatic step(input bit ena, input logic [3:0] wea, input int word, input int lane,
                      input logic [31:0] din, input bit clr);
    bit           wr, rd, ld_exp;
    int           prev_count;
    logic [127:0] tmp;
    wr = ena && (wea != 4'd0);
    rd = ena && (wea == 4'd0);
    load_clear = clr;
    bram_ena   = ena;
    bram_wea   = wea;
    bram_addra = {12'(word), 2'(lane), 2'($urandom)};
    bram_din   = din;
    prev_count  = m_count;
    last_commit = 1'b0;
    if (clr) begin
      m_count = 0; m_seq = 1'b0; m_exp = 0;
    end else if (wr) begin
      if (lane == 0 || (lane == m_exp && word == m_addr)) begin
        if (lane == 0) m_addr = word;
        for (int b = 0; b < 4; b++) if (wea[b]) sh[lane][b] = din[b*8 +: 8];
        m_exp = lane + 1;
        if (m_exp == LANES) begin
          m_exp = 0;
          last_commit = 1'b1;
          c_addr = 12'(m_addr);
          c_data = shadow_word();
          ref_mem[4'(m_addr)] = c_data;
          if (m_count < EXPW) m_count++;
        end
      end else begin
        m_seq = 1'b1; m_exp = 0;
      end
    end
    if (rd) begin
      tmp = 128'(ref_mem[4'(word)]);
      rd_due.push_back(cyc + 3);
      rd_val.push_back(tmp[lane*32 +: 32]);
    end
    #1;
    chk("mem_re", 128'(mem_re), 128'(rd));
    if (rd) chk("mem_raddr", 128'(mem_raddr), 128'(word));
    @(posedge clk);
    cyc++;
    #1;
    ld_exp = !clr && (prev_count == EXPW);
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      dout_exp = rd_val.pop_front();
      void'(rd_due.pop_front());
    end
    chk("mem_we", 128'(mem_we), 128'(last_commit));
    if (last_commit) begin
      chk("mem_waddr", 128'(mem_waddr), 128'(c_addr));
      chk("mem_wdata", 128'(mem_wdata), 128'(c_data));
    end
    chk("words_written", 128'(words_written), 128'(m_count));
    chk("load_done", 128'(load_done), 128'(ld_exp));
    chk("seq_err", 128'(seq_err), 128'(m_seq));
    chk("bram_dout", 128'(bram_dout), 128'(dout_exp));
  endtask

  task automatic idle();
    step(1'b0, 4'(($urandom)), 0, 0, 32'd0, 1'b0);
  endtask

  task automatic wr_word(input int word, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    step(1'b1, 4'hF, word, 0, d0, 1'b0);
    step(1'b1, 4'hF, word, 1, d1, 1'b0);
    step(1'b1, 4'hF, word, 2, d2, 1'b0);
    step(1'b1, 4'hF, word, 3, d3, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_clear = 1'b0; bram_ena = 1'b1; bram_wea = 4'd0;
    bram_addra = 16'h0050; bram_din = 32'd0;
    #1;
    chk("rst_mem_re", 128'(mem_re), 128'd0);
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    chk("rst_mem_we", 128'(mem_we), 128'd0);
    chk("rst_mem_waddr", 128'(mem_waddr), 128'd0);
    chk("rst_mem_wdata", 128'(mem_wdata), 128'd0);
    chk("rst_bram_dout", 128'(bram_dout), 128'd0);
    chk("rst_words", 128'(words_written), 128'd0);
    chk("rst_load_done", 128'(load_done), 128'd0);
    chk("rst_seq_err", 128'(seq_err), 128'd0);
    rst_n = 1'b1; bram_ena = 1'b0;
    m_exp = 0; m_count = 0; m_seq = 1'b0; dout_exp = 32'd0;
    rd_due.delete(); rd_val.delete();
  endtask

  initial begin
    int w_cur, s_lane, r;
    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 7) ? PRE7 : 103'd0;
    for (int l = 0; l < 4; l++) for (int b = 0; b < 4; b++) sh[l][b] = 8'd0;
    do_reset();
    preload = 1'b0;

    // In-order write of word 5.
    wr_word(5, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF);
    chk("s1_waddr", 128'(mem_waddr), 128'd5);
    chk("s1_wdata", 128'(mem_wdata), 128'({7'h7F, 96'h333333332222222211111111}));
    chk("s1_words", 128'(words_written), 128'd1);
    idle();
    chk("s1_we_single_pulse", 128'(mem_we), 128'd0);

    // Partial strobes over stale shadow lane 0.
    step(1'b1, 4'b0101, 8, 0, 32'hAABBCCDD, 1'b0);
    step(1'b1, 4'hF, 8, 1, 32'h01010101, 1'b0);
    step(1'b1, 4'hF, 8, 2, 32'h02020202, 1'b0);
    step(1'b1, 4'hF, 8, 3, 32'h03030303, 1'b0);
    chk("s2_lane0", 128'(mem_wdata[31:0]), 128'(32'h11BB11DD));
    idle();

    // Lane order error, then a clean word, then clear.
    step(1'b1, 4'hF, 5, 0, 32'h55555555, 1'b0);
    step(1'b1, 4'hF, 5, 2, 32'h66666666, 1'b0);
    chk("s3_seq_err", 128'(seq_err), 128'd1);
    chk("s3_no_commit", 128'(mem_we), 128'd0);
    wr_word(6, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
    chk("s3_commit_addr", 128'(mem_waddr), 128'd6);
    chk("s3_seq_err_sticky", 128'(seq_err), 128'd1);
    idle();
    step(1'b0, 4'd0, 0, 0, 32'd0, 1'b1);
    chk("s3_seq_err_cleared", 128'(seq_err), 128'd0);

    // Read latency and back-to-back reads.
    step(1'b1, 4'd0, 5, 1, 32'd0, 1'b0);
    step(1'b1, 4'd0, 7, 0, 32'd0, 1'b0);
    idle();
    chk("s4_rd_plus3", 128'(bram_dout), 128'(32'h22222222));
    idle();
    chk("s4_rd_plus4", 128'(bram_dout), 128'(32'hCAFEF00D));
    step(1'b1, 4'd0, 5, 3, 32'd0, 1'b0);
    idle(); idle(); idle();
    chk("s4_top_lane", 128'(bram_dout), 128'(32'h0000007F));

    // Load done and saturation.
    step(1'b0, 4'd0, 0, 0, 32'd0, 1'b1);
    wr_word(10, 32'h0A, 32'h1A, 32'h2A, 32'h3A); idle();
    wr_word(11, 32'h0B, 32'h1B, 32'h2B, 32'h3B); idle();
    wr_word(12, 32'h0C, 32'h1C, 32'h2C, 32'h3C);
    chk("s5_words3", 128'(words_written), 128'd3);
    chk("s5_done_not_yet", 128'(load_done), 128'd0);
    idle();
    chk("s5_done_rise", 128'(load_done), 128'd1);
    wr_word(13, 32'h0D, 32'h1D, 32'h2D, 32'h3D);
    chk("s5_saturate", 128'(words_written), 128'd3);
    chk("s5_commit_after_done", 128'(mem_we), 128'd1);
    idle();
    step(1'b1, 4'hF, 14, 0, 32'h0E, 1'b0);
    step(1'b1, 4'hF, 14, 1, 32'h1E, 1'b0);
    step(1'b1, 4'hF, 14, 2, 32'h2E, 1'b0);
    step(1'b1, 4'hF, 14, 3, 32'h3E, 1'b1);
    chk("s5_clr_no_commit", 128'(mem_we), 128'd0);
    chk("s5_clr_words", 128'(words_written), 128'd0);
    chk("s5_clr_done", 128'(load_done), 128'd0);
    idle();

    // Randomized traffic against the model.
    w_cur = 0; s_lane = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55) begin
        step(1'b1, 4'($urandom_range(1, 15)), w_cur, s_lane, $urandom, 1'b0);
        s_lane = (s_lane + 1) % LANES;
        if (s_lane == 0) w_cur = int'($urandom_range(0, 15));
      end else if (r < 65) begin
        step(1'b1, 4'($urandom_range(1, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), $urandom, 1'b0);
      end else if (r < 85) begin
        step(1'b1, 4'd0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 32'd0, 1'b0);
      end else if (r < 90) begin
        step(1'($urandom), 4'($urandom), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), $urandom, 1'b1);
      end else begin
        idle();
      end
      if (last_commit) idle();
    end
    repeat (4) idle();

    // Reset mid-word.
    step(1'b1, 4'hF, 9, 0, 32'h99990000, 1'b0);
    step(1'b1, 4'hF, 9, 1, 32'h99991111, 1'b0);
    do_reset();
    step(1'b1, 4'hF, 9, 1, 32'h99992222, 1'b0);
    chk("s6_seq_err", 128'(seq_err), 128'd1);
    chk("s6_no_commit", 128'(mem_we), 128'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/gat_bram_lane_adapter.md
# gat_bram_lane_adapter

Parametrised host-to-BRAM port adapter for the GAT accelerator's block design boundary. It maps a 32-bit, byte-addressed BRAM-controller port onto one internal memory of arbitrary width MEM_WIDTH by splitting each internal word into TOP_WIDTH lanes. Writes assemble into a shadow word and commit in one wide write; reads use a fixed-latency lane select. Load progress is tracked so the register bank receives a `load_done` flag and a word count. The block replaces per-memory slicing adapters for memories wider than 32 bits, such as WH rows, softmax sums and new features.

## Interface
Parameters:
- TOP_WIDTH, 32, host data width; must be a multiple of 8.
- MEM_WIDTH, 103, internal memory word width.
- MEM_DEPTH, 2708, internal memory depth.
- MEM_RD_LATENCY, 2, internal memory read latency in cycles; must be ≥1.
- EXPECTED_WORDS, MEM_DEPTH, number of committed wide writes that raises `load_done`.
- LANES (derived), ceil(MEM_WIDTH/TOP_WIDTH).
- LANE_W (derived), max(1, $clog2(LANES)); lane stride is 2^LANE_W.
- MEM_ADDR_W (derived), $clog2(MEM_DEPTH).
- STRB_W (derived), TOP_WIDTH/8.

Ports (all signals synchronous to clk):
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- load_clear  in  1  start a new load; clears the counter, `seq_err` and lane tracking.
- bram_ena  in  1  host access strobe.
- bram_wea  in  STRB_W  byte write strobes. Zero with `bram_ena`=1 means a read.
- bram_addra  in  MEM_ADDR_W+LANE_W+2  host byte address, laid out as {mem_addr, lane, 2'b00}. Bits [1:0] are ignored.
- bram_din  in  TOP_WIDTH  host write data.
- bram_dout  out  TOP_WIDTH  host read data.
- mem_we  out  1  wide write enable.
- mem_waddr  out  MEM_ADDR_W  wide write address.
- mem_wdata  out  MEM_WIDTH  wide write data.
- mem_re  out  1  read enable.
- mem_raddr  out  MEM_ADDR_W  read address.
- mem_rdata  in  MEM_WIDTH  read data, valid MEM_RD_LATENCY cycles after `mem_re`.
- load_done  out  1  high when `words_written` equals EXPECTED_WORDS.
- words_written  out  MEM_ADDR_W+1  count of committed wide writes.
- seq_err  out  1  sticky lane-order violation flag.

## Operation
Write path (`bram_ena`=1, `bram_wea`≠0):
- The lane index is addr[LANE_W+1:2]; the word address is the upper address bits.
- Lanes must arrive in order 0..LANES-1, all with the same word address. An expected-lane register tracks this.
- Lane 0 always restarts assembly: it latches the word address and sets expected lane = 1, even if an assembly was in progress. Restarting is not an error.
- A lane equal to expected, with a matching word address, merges byte-wise into the shadow word. Only bytes with a strobe set are written; unstrobed bytes keep their previous shadow value.
- On lane LANES-1, the block commits: mem_we=1, mem_waddr = latched address, mem_wdata = shadow including this lane's merged bytes. The expected lane returns to 0.
- Bits of the top lane above MEM_WIDTH are discarded.
- A lane that is out of order or has a mismatched address:
  - sets `seq_err`;
  - is discarded;
  - resets expected lane to 0;
  - produces no commit.
- A lane index ≥ LANES (padding slot) is ignored silently and does not change state.
- The shadow word is not cleared between words. With a partial strobe on the first write, stale bytes are committed; this is intended.

Read path (`bram_ena`=1, `bram_wea`=0):
- Same cycle: mem_re=1 (combinational), mem_raddr = word address.
- The lane index is pushed into a MEM_RD_LATENCY-deep delay line.
- When `mem_rdata` is valid, `bram_dout` is registered with the selected lane, zero-extended.
- A padding lane index returns 0.
- Back-to-back reads are supported at one per cycle.
- `bram_dout` holds its value between reads.

Counter and flags:
- Each commit increments `words_written`, saturating at EXPECTED_WORDS.
- `load_done` = (`words_written` == EXPECTED_WORDS), registered.
- Further commits after `load_done` still write memory.

Priority and reset:
- `load_clear` has priority over a same-cycle write: the write is dropped, and counter, `seq_err` and expected lane are cleared.
- A read in the same cycle as `load_clear` proceeds.
- Reset mid-assembly discards the partial word; no commit occurs.

## Timing
- Reset values:
  - mem_we=0, mem_waddr=0, mem_wdata=0;
  - bram_dout=0, words_written=0, load_done=0, seq_err=0;
  - expected lane = 0, read delay line valid bits = 0.
- `mem_re` is combinational from `bram_ena` and `bram_wea`; it is 0 while rst_n=0.
- Commit latency: `mem_we` is registered and pulses for exactly 1 cycle, the cycle after the last-lane write.
- `words_written` updates in that same cycle; `load_done` rises one cycle later.
- Read latency: `bram_dout` is valid MEM_RD_LATENCY+1 cycles after the read request (3 with default parameters).

## Test plan
Defaults for all scenarios: MEM_WIDTH=103, LANES=4, MEM_RD_LATENCY=2.

1. In-order write. Write addresses 0x50, 0x54, 0x58, 0x5C with data 0x11111111, 0x22222222, 0x33333333, 0xFFFFFFFF and all strobes set.
   - Required: one `mem_we` pulse, mem_waddr=5, mem_wdata = {7'h7F, 96'h333333332222222211111111}, words_written=1.
2. Byte strobes. Write lane 0 with wea=4'b0101 and din=0xAABBCCDD over an earlier shadow of 0x11111111, then complete lanes 1–3.
   - Required: committed lane 0 = 0x11BB11DD.
3. Order error.
   - Write lane 0 to word 5, then lane 2 to word 5. Required: seq_err=1, no commit.
   - Then write lanes 0..3 to word 6. Required: commit to address 6; seq_err stays 1 until `load_clear`.
4. Read latency. Issue back-to-back reads at 0x54 and 0x70 (lane 0 of word 7), with the model memory returning word 5 = scenario 1's data.
   - Required: bram_dout = 0x22222222 at cycle +3, then lane 0 of word 7 at +4.
   - A read at 0x5C returns 0x0000007F.
5. Load done. Set EXPECTED_WORDS=3 and commit 4 words.
   - Required: load_done rises one cycle after the 3rd commit; words_written saturates at 3.
   - `load_clear` on the same cycle as a lane-3 write: no commit, words_written=0, load_done=0.
6. Reset mid-word. Assert reset after lanes 0–1 of a word.
   - Required: all outputs return to 0.
   - A subsequent lane 1 write flags seq_err.
